// File: rtl/jojo_pkg.sv
// Shared game encodings and BCD types for the score and display paths.
package jojo_pkg;

    localparam int DIGITS_DEFAULT = 4;

    typedef logic [3:0] bcd_digit_t;

    typedef enum logic [2:0] {
        GS_INITIAL   = 3'd0,
        GS_START     = 3'd1,
        GS_PLAY      = 3'd2,
        GS_COLLISION = 3'd3,
        GS_GAMEOVER  = 3'd4
    } gamestate_t;

    typedef enum logic [1:0] {
        SK_IDLE,
        SK_RUN,
        SK_COMMIT,
        SK_DONE
    } sk_state_t;

    // Undefined encodings 5..7 fold onto Initial.
    function automatic gamestate_t norm_gamestate(input logic [2:0] raw);
        if (raw > 3'd4) begin
            return GS_INITIAL;
        end
        return gamestate_t'(raw);
    endfunction

endpackage

// File: rtl/bcd_counter.sv
// Multi-digit BCD up-counter with synchronous clear, saturating at all nines.
module bcd_counter
    import jojo_pkg::*;
#(
    parameter int DIGITS = DIGITS_DEFAULT
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clr,
    input  logic                inc,
    output logic [4*DIGITS-1:0] count
);

    bcd_digit_t          digit_q [DIGITS];
    logic [DIGITS-1:0]   is_nine;
    logic [DIGITS-1:0]   carry;
    logic                all_nine;

    assign all_nine = &is_nine;
    // Blocking the chain at all-nines is what makes the counter saturate.
    assign carry[0] = inc & ~all_nine;

    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
            bcd_digit_t digit_d;

            assign is_nine[gi] = (digit_q[gi] == 4'd9);

            if (gi < DIGITS - 1) begin : g_carry
                assign carry[gi+1] = carry[gi] & is_nine[gi];
            end

            always_comb begin
                digit_d = digit_q[gi];
                if (clr) begin
                    digit_d = '0;
                end else if (carry[gi]) begin
                    digit_d = is_nine[gi] ? 4'd0 : digit_q[gi] + 4'd1;
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    digit_q[gi] <= '0;
                end else begin
                    digit_q[gi] <= digit_d;
                end
            end

            assign count[4*gi +: 4] = digit_q[gi];
        end
    endgenerate

endmodule

// File: rtl/score_keeper.sv
// BCD survival score with Gameover high-score commit.
// Optional high-score register/comparator enabled by defining SCORE_HIGH_EN.
module score_keeper
    import jojo_pkg::*;
#(
    parameter int TICK_DIV = 10_000_000,
    parameter int DIGITS   = DIGITS_DEFAULT
) (
    input  logic                clk,
    input  logic                hard_reset_n,
    input  logic                game_en,
    input  logic                game_reset,
    input  logic [2:0]          gamestate,
    output logic [4*DIGITS-1:0] score_bcd,
    output logic [4*DIGITS-1:0] high_bcd,
    output logic                new_high,
    output logic                score_tick
);

    localparam int             PW         = $clog2(TICK_DIV);
    localparam logic [PW-1:0]  PRESC_LAST = PW'(TICK_DIV - 1);

    sk_state_t      state_q, state_d;
    gamestate_t     gs, prev_gs_q;
    logic [PW-1:0]  presc_q, presc_d;
    logic           tick_q, tick_d;
    logic           cnt_clr, cnt_inc;
    logic           gameover_edge, playing;

    assign gs            = norm_gamestate(gamestate);
    assign gameover_edge = (gs == GS_GAMEOVER) && (prev_gs_q != GS_GAMEOVER);
    assign playing       = (gs == GS_PLAY) && game_en;

    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        tick_d  = 1'b0;
        cnt_clr = 1'b0;
        cnt_inc = 1'b0;
        case (state_q)
            SK_IDLE: begin
                if (game_reset && game_en) begin
                    state_d = SK_RUN;
                    presc_d = '0;
                    cnt_clr = 1'b1;
                end
            end
            SK_RUN: begin
                // Restart beats Gameover, which beats a pending point.
                if (game_reset) begin
                    presc_d = '0;
                    cnt_clr = 1'b1;
                end else if (gameover_edge) begin
                    state_d = SK_COMMIT;
                end else if (playing) begin
                    if (presc_q == PRESC_LAST) begin
                        presc_d = '0;
                        cnt_inc = 1'b1;
                        tick_d  = 1'b1;
                    end else begin
                        presc_d = presc_q + 1'b1;
                    end
                end
            end
            SK_COMMIT: begin
                state_d = SK_DONE;
            end
            SK_DONE: begin
                if (game_reset) begin
                    state_d = SK_IDLE;
                end
            end
            default: begin
                state_d = SK_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge hard_reset_n) begin
        if (!hard_reset_n) begin
            state_q   <= SK_IDLE;
            presc_q   <= '0;
            tick_q    <= 1'b0;
            prev_gs_q <= GS_INITIAL;
        end else begin
            state_q   <= state_d;
            presc_q   <= presc_d;
            tick_q    <= tick_d;
            prev_gs_q <= gs;
        end
    end

    bcd_counter #(
        .DIGITS (DIGITS)
    ) u_score (
        .clk   (clk),
        .rst_n (hard_reset_n),
        .clr   (cnt_clr),
        .inc   (cnt_inc),
        .count (score_bcd)
    );

    assign score_tick = tick_q;

`ifdef SCORE_HIGH_EN
    logic [4*DIGITS-1:0] high_q, high_d;
    logic                new_high_q, new_high_d;
    logic                score_gt, gt_decided;

    // Most significant differing digit decides.
    always_comb begin
        score_gt   = 1'b0;
        gt_decided = 1'b0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            if (!gt_decided && (score_bcd[4*i +: 4] != high_q[4*i +: 4])) begin
                score_gt   = (score_bcd[4*i +: 4] > high_q[4*i +: 4]);
                gt_decided = 1'b1;
            end
        end
    end

    always_comb begin
        high_d     = high_q;
        new_high_d = new_high_q;
        if ((state_q == SK_IDLE) && game_reset && game_en) begin
            new_high_d = 1'b0;
        end else if ((state_q == SK_COMMIT) && score_gt) begin
            high_d     = score_bcd;
            new_high_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge hard_reset_n) begin
        if (!hard_reset_n) begin
            high_q     <= '0;
            new_high_q <= 1'b0;
        end else begin
            high_q     <= high_d;
            new_high_q <= new_high_d;
        end
    end

    assign high_bcd = high_q;
    assign new_high = new_high_q;
`else
    assign high_bcd = '0;
    assign new_high = 1'b0;
`endif

endmodule

// File: doc/score_keeper.md
# score_keeper

Score and high-score tracker sitting directly downstream of the game-control FSM. Consumes its `gamestate`, `game_en` and `game_reset` outputs, accumulates a BCD survival score while the game is in Play, freezes it during Collision recovery, and commits a high score on entry to Gameover. Drives the score/high-score digits consumed by the seven-segment and VGA text paths.

## Interface
- `TICK_DIV`, 10_000_000: clk cycles per score point while playing; minimum 2.
- `DIGITS`, 4: number of BCD digits in score and high score.
- `clk` input 1: system clock, all logic on rising edge.
- `hard_reset_n` input 1: reset, asynchronous assert, active-low.
- `game_en` input 1: game-enable level from the game-control FSM.
- `game_reset` input 1: one-cycle game-restart strobe from the FSM.
- `gamestate` input 3: FSM state; 0 Initial, 1 Start, 2 Play, 3 Collision, 4 Gameover.
- `score_bcd` output 4*DIGITS: current score; digit 0 in bits [3:0].
- `high_bcd` output 4*DIGITS: best score since reset.
- `new_high` output 1: level; last committed game beat the previous high.
- `score_tick` output 1: one-cycle pulse on each point added.

## Operation
- Reset: `score_bcd`=0, `high_bcd`=0, `new_high`=0, `score_tick`=0, prescaler=0, internal state IDLE, `prev_state`=Initial.
- Internal states: IDLE, RUN, COMMIT, DONE.
- IDLE -> RUN when `game_reset`=1 and `game_en`=1 on the same cycle (the Start->Play edge). Score and prescaler clear. `new_high` clears.
- RUN:
  - Prescaler counts only when `gamestate`==Play and `game_en`=1.
  - In Collision the prescaler holds its value and does not clear.
  - When the prescaler reaches TICK_DIV-1 it wraps to 0, and on the next edge score increments by 1 (BCD ripple carry) and `score_tick` pulses.
- Saturation: at all digits 9 the score holds. `score_tick` still pulses and the prescaler still wraps.
- RUN -> COMMIT on the cycle `gamestate`==Gameover and `prev_state`!=Gameover (registered edge detect).
- COMMIT, one cycle: if score > high (unsigned digit-wise compare, MSD first), then `high_bcd` <= score and `new_high` <= 1. No increment occurs. Next state DONE.
- DONE: score and high hold. On `game_reset` go to IDLE with score still visible, then await the Start->Play strobe.
- Any `game_reset` in RUN clears score and prescaler and stays in RUN. `high_bcd` is never cleared except by `hard_reset_n`.
- Simultaneous events:
  - `game_reset` beats a tick on the same cycle: score becomes 0 and no pulse is issued.
  - A Gameover edge on the same cycle as a prescaler wrap drops that point.
- Gamestate values 5–7 are treated as Initial.

## Timing
- Tick-to-score latency is 1 cycle: `score_bcd` and `score_tick` are registered together.
- First point arrives TICK_DIV cycles after the first Play cycle.
- Gameover edge to `high_bcd`/`new_high` update: 2 cycles (edge-detect register, then COMMIT).
- Asynchronous reset mid-game returns all outputs to reset values immediately. Reset deassertion is synchronous to `clk` upstream.

## Configuration
- `SCORE_HIGH_EN`, defined:
  - High-score register, comparator and COMMIT behaviour are present as above.
- `SCORE_HIGH_EN`, undefined:
  - `high_bcd` is tied to 0 and `new_high` to 0.
  - COMMIT still occurs but only sequences to DONE.
  - Score behaviour is unchanged.

## Structure
- Shared package `jojo_pkg`:
  - Gamestate encodings (Initial/Start/Play/Collision/Gameover).
  - BCD digit typedef.
  - DIGITS default.
- Sub-module `bcd_counter` (parameter DIGITS):
  - Synchronous clear and increment enable.
  - Saturating at all-9s.
  - Carry chain per digit.
  - Instantiated once for the score.

## Test plan
Bench uses TICK_DIV=4, DIGITS=2.
- Hold `hard_reset_n`=0, then release: all outputs read 0, state IDLE.
- `game_reset`+`game_en` pulse, then `gamestate`=Play for 12 cycles: `score_bcd`=0x03 and exactly 3 `score_tick` pulses, the first on cycle 5.
- Play 6 cycles, Collision 100 cycles, Play 2 cycles: score=0x02 (prescaler held across Collision).
- Drive 400 cycles of Play: score saturates at 0x99 and never wraps to 0x00.
- Score 0x07, then Gameover: 2 cycles later `high_bcd`=0x07 and `new_high`=1. A second game ending at 0x05 leaves `high_bcd`=0x07 with `new_high`=0.
- `game_reset` coincident with a prescaler wrap: score=0x00 and no `score_tick`. `hard_reset_n` pulsed mid-Play clears `high_bcd` too.
